// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state encoding, default parameters and timer-width helper for ring_freq_meter.
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;
  localparam int DEF_GATE_CYCLES = 1024;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_CNT_W = 16;
  function automatic int timer_w(input int gate, input int settle);
    return $clog2(gate > settle ? gate : settle);
  endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer plus history flop giving a one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic edge_pulse
);
  logic s1, s2, prev;
  always_ff @(posedge clk)
    if (rst) {prev, s2, s1} <= '0;
    else {prev, s2, s1} <= {s2, s1, osc_in};
  assign edge_pulse = s2 & ~prev;
endmodule

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts ring-oscillator edges over a fixed gate window and hands off the count.
// Define FREQ_METER_SAT_EN for a saturating counter with an ovf output; otherwise the count wraps.
module ring_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
`ifdef FREQ_METER_SAT_EN
  ,
  output logic             ovf
`endif
);
  localparam int TW = timer_w(GATE_CYCLES, SETTLE_CYCLES);
  state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic edge_pulse, settle_done, gate_done, hs;
  edge_sync u_sync (.clk(clk), .rst(rst), .osc_in(osc_in), .edge_pulse(edge_pulse));
  assign settle_done = state == SETTLE && timer == TW'(SETTLE_CYCLES - 1);
  assign gate_done = state == GATE && timer == TW'(GATE_CYCLES - 1);
  assign result_valid = state == REPORT;
  assign busy = state != IDLE;
  assign hs = result_valid && result_ready;
`ifdef FREQ_METER_SAT_EN
  logic sat_hit, sat_now;
  assign sat_now = edge_pulse && &cnt;
  assign cnt_nxt = edge_pulse && !(&cnt) ? cnt + 1'b1 : cnt;
  always_ff @(posedge clk)
    if (rst) begin
      sat_hit <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sat_hit <= settle_done ? 1'b0 : state == GATE ? sat_hit | sat_now : sat_hit;
      if (gate_done) ovf <= sat_hit | sat_now;
    end
`else
  assign cnt_nxt = cnt + CNT_W'(edge_pulse);
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SETTLE : IDLE;
      SETTLE:  state_nxt = settle_done ? GATE : SETTLE;
      GATE:    state_nxt = gate_done ? REPORT : GATE;
      default: state_nxt = hs ? (start ? SETTLE : IDLE) : REPORT;
    endcase
  end
  // result captures cnt_nxt so a pulse in the final gate cycle is included
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      osc_en <= 1'b0;
      timer <= '0;
      cnt <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      osc_en <= state_nxt == SETTLE || state_nxt == GATE;
      timer <= (state == SETTLE || state == GATE) && !settle_done && !gate_done ? timer + 1'b1 : '0;
      cnt <= settle_done ? '0 : state == GATE ? cnt_nxt : cnt;
      if (gate_done) result <= cnt_nxt;
    end
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: scoreboard bench driving an 8-bit and a 4-bit meter from the same stimulus.
module tb_ring_freq_meter;
  localparam int G = 100;
  localparam int S = 4;
  typedef struct {int r8; int r4; bit o4;} exp_t;
  logic clk = 0, rst = 1, start = 0, osc = 0, ready = 0;
  logic osc_en, busy, rv, osc_en4, busy4, rv4;
  logic [7:0] res;
  logic [3:0] res4;
`ifdef FREQ_METER_SAT_EN
  logic ovf, ovf4;
`endif
  exp_t q[$];
  int tests = 0, fails = 0, gc = 0, g0 = 0, mode = 0, period = 10, phase = 0;
  int n, en;
  always #5 clk = ~clk;
  ring_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc), .osc_en(osc_en), .busy(busy),
    .result(res), .result_valid(rv), .result_ready(ready)
`ifdef FREQ_METER_SAT_EN
    , .ovf(ovf)
`endif
  );
  ring_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc), .osc_en(osc_en4), .busy(busy4),
    .result(res4), .result_valid(rv4), .result_ready(ready)
`ifdef FREQ_METER_SAT_EN
    , .ovf(ovf4)
`endif
  );
  // osc level seen at the k-th edge after the start edge
  function automatic bit pat(input int k);
    if (mode == 1) return k == 2 || k == 102 || k == 104;
    return ((k + phase + 1000) % period) < period / 2;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    gc++;
    @(negedge clk);
    osc = pat(gc + 1 - g0);
  endtask
  // a rise first sampled at edge k pulses during gate iff S-1 <= k <= S+G-2
  task automatic go();
    int raw;
    exp_t e;
    raw = 0;
    g0 = gc + 1;
    osc = pat(0);
    start = 1;
    for (int k = S - 1; k <= S + G - 2; k++) if (pat(k) && !pat(k - 1)) raw++;
`ifdef FREQ_METER_SAT_EN
    e.r8 = raw > 255 ? 255 : raw;
    e.r4 = raw > 15 ? 15 : raw;
    e.o4 = raw > 15;
`else
    e.r8 = raw % 256;
    e.r4 = raw % 16;
    e.o4 = 0;
`endif
    q.push_back(e);
  endtask
  task automatic wait_valid(output int cyc, output int en_cnt);
    cyc = 0;
    en_cnt = 0;
    while (!rv && cyc < 300) begin
      tick();
      start = 0;
      cyc++;
      en_cnt += int'(osc_en);
    end
    if (!rv) check("valid_timeout", rv, 1);
  endtask
  task automatic take(input bit again);
    exp_t e;
    ready = 1;
    check("sb_depth", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("result", res, e.r8);
      check("result4", res4, e.r4);
      check("valid4", rv4, 1);
`ifdef FREQ_METER_SAT_EN
      check("ovf4", ovf4, e.o4);
      check("ovf", ovf, 0);
`endif
    end
    if (again) go();
    tick();
    ready = 0;
    start = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] r0;
    logic [3:0] r40;
    bit ok;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_osc_en", osc_en, 0);
    check("rst_valid", rv, 0);
    check("rst_result", res, 0);
    rst = 0;
    tick();
    go();
    wait_valid(n, en);
    check("latency", n, 105);
    check("osc_en_cycles", en, 104);
    check("report_osc_en", osc_en, 0);
    take(0);
    check("idle_after_hs", busy, 0);
    period = 7;
    phase = 3;
    go();
    wait_valid(n, en);
    r0 = res;
    r40 = res4;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
      if (res !== r0 || res4 !== r40 || !rv || !rv4 || osc_en || !busy) ok = 0;
    end
    start = 0;
    check("report_hold", ok, 1);
    take(0);
    check("idle_after_hold", busy, 0);
    period = 9;
    phase = 2;
    go();
    tick();
    start = 0;
    repeat (50) tick();
    start = 1;
    tick();
    start = 0;
    wait_valid(n, en);
    check("start_ignored", 52 + n, 105);
    period = 6;
    phase = 1;
    take(1);
    check("b2b_busy", busy, 1);
    check("b2b_osc_en", osc_en, 1);
    wait_valid(n, en);
    check("b2b_latency", n, 104);
    take(0);
    period = 8;
    phase = 0;
    go();
    tick();
    start = 0;
    repeat (53) tick();
    check("in_gate", busy & osc_en, 1);
    rst = 1;
    tick();
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_osc_en", osc_en, 0);
    check("abort_valid", rv, 0);
    check("abort_result", res, 0);
    check("abort_result4", res4, 0);
    void'(q.pop_front());
    period = 5;
    phase = 4;
    go();
    wait_valid(n, en);
    check("post_abort_latency", n, 105);
    take(0);
    period = 4;
    phase = 0;
    go();
    wait_valid(n, en);
    take(0);
    mode = 1;
    go();
    wait_valid(n, en);
    repeat (3) tick();
    take(0);
    mode = 0;
    repeat (3) tick();
    check("final_idle", busy | busy4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ring_freq_meter.md
RING_FREQ_METER -- requirements
Module: ring_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1024, the measurement window length in clk cycles (>=2).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, the clk cycles between oscillator enable and gate open (>=1).
REQ-003 SHALL have parameter CNT_W, default 16, the edge-count result width.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle measurement request.
REQ-007 SHALL have port osc_in, input, 1, the divided ring-oscillator tap, asynchronous to clk, with a rising-edge rate below clk/4.
REQ-008 SHALL have port osc_en, output, 1, the enable driven to the ring oscillator.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port result, output, CNT_W, the rising-edge count of the last window.
REQ-011 SHALL have port result_valid, output, 1, which qualifies result.
REQ-012 SHALL have port result_ready, input, 1, the consumer accept signal.

Function
REQ-013 SHALL sample osc_in through a 2-flop synchronizer, then a third flop; edge_pulse = sync & ~prev.
REQ-014 SHALL implement the FSM states IDLE, SETTLE, GATE, REPORT.
REQ-015 IDLE: start=1 -> SETTLE next cycle; otherwise remain in IDLE.
REQ-016 SETTLE: osc_en=1; a timer counts SETTLE_CYCLES cycles, then -> GATE; the edge counter clears on entry to GATE.
REQ-017 GATE: osc_en=1; for exactly GATE_CYCLES cycles the counter increments by 1 on each cycle where edge_pulse=1; after the last gate cycle -> REPORT.
REQ-018 An edge_pulse in the final GATE cycle SHALL be counted; edge_pulses in SETTLE or REPORT SHALL NOT be counted.
REQ-019 REPORT: osc_en=0, result_valid=1, and result is stable until result_valid & result_ready.
REQ-020 REPORT on handshake: if start=1 in the same cycle -> SETTLE; else -> IDLE.
REQ-021 start SHALL be ignored in SETTLE and GATE; no queuing.
REQ-022 result SHALL hold its last value in IDLE; result_valid is only high in REPORT.
REQ-023 The count SHALL wrap modulo 2^CNT_W unless FREQ_METER_SAT_EN is defined.
REQ-024 The first result_valid SHALL occur exactly 1+SETTLE_CYCLES+GATE_CYCLES cycles after the start cycle.
REQ-025 osc_en SHALL be registered, with no combinational path from start.

Reset
REQ-026 rst=1 at a clk edge SHALL set: state=IDLE, osc_en=0, busy=0, result=0, result_valid=0, counter=0, timers=0, synchronizer flops=0.
REQ-027 rst mid-GATE or mid-REPORT SHALL abort the measurement; the pending result is discarded.
REQ-028 rst SHALL take priority over start and over the handshake.

Configuration
REQ-029 Defined macro FREQ_METER_SAT_EN: the counter saturates at 2^CNT_W-1, and output port ovf (1 bit, reset 0) is set with result_valid when saturation occurred in that window.
REQ-030 FREQ_METER_SAT_EN undefined: the counter wraps, and port ovf does not exist.

Structure
REQ-031 Package freq_meter_pkg SHALL hold the FSM state encoding (2-bit), default parameter constants, and a timer-width helper (clog2 of the max of GATE_CYCLES and SETTLE_CYCLES).
REQ-032 Sub-module edge_sync SHALL contain the 2-flop synchronizer, the prev flop, and the rising-edge pulse, with its own clk/rst.
REQ-033 The top SHALL contain the FSM, the shared settle/gate timer, the edge counter and the result register.

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8 unless noted)
REQ-034 osc_in square wave with period 10 clk, start pulse -> result_valid at start+105 cycles, result=10 (+/-1 by phase); osc_en high for exactly 104 cycles.
REQ-035 result_ready held 0 for 20 cycles in REPORT -> result and result_valid stable, osc_en=0, start ignored; ready=1 -> IDLE next cycle.
REQ-036 start asserted together with the handshake -> SETTLE next cycle; busy never drops; second result correct.
REQ-037 rst pulsed at gate cycle 50 -> next cycle: IDLE, osc_en=0, result_valid=0, result=0; a following start measures normally.
REQ-038 CNT_W=4, osc_in period 4 clk (25 edges) -> result=9 without the macro; with FREQ_METER_SAT_EN, result=15 and ovf=1.
REQ-039 osc_in rising edge placed in the final gate cycle and another in the first REPORT cycle -> only the first is counted.
